axi_lite_arbiter_2x1: RTL and testbench
=======================================

# axi_lite_arbiter_2x1

Two-requester AXI4-Lite arbiter that shares one `axi_lite_slave` between two masters (requesters 0 and 1). The write path (AW/W/B) and the read path (AR/R) are arbitrated independently. Each path uses round-robin priority and allows one outstanding transaction. The block sits between the requester interfaces and the slave port, using the same channel signal set as the slave (no BRESP/RRESP).

## Interface
- ADDR_WIDTH, 4, address width on all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- ACLK  input  1  clock, all logic on rising edge
- ARESETn  input  1  asynchronous active-low reset
- Sn_AWADDR/Sn_AWVALID in, Sn_AWREADY out (n=0,1)  ADDR_WIDTH/1/1  requester-n write address channel
- Sn_WDATA/Sn_WSTRB/Sn_WVALID in, Sn_WREADY out  DATA_WIDTH/DATA_WIDTH/8/1/1  requester-n write data channel
- Sn_BVALID out, Sn_BREADY in  1/1  requester-n write response channel
- Sn_ARADDR/Sn_ARVALID in, Sn_ARREADY out  ADDR_WIDTH/1/1  requester-n read address channel
- Sn_RDATA/Sn_RVALID out, Sn_RREADY in  DATA_WIDTH/1/1  requester-n read data channel
- M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY, M_ARADDR, M_ARVALID, M_RREADY  output  matching widths  toward the slave
- M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RDATA, M_RVALID  input  matching widths  from the slave
- GNT_W  output  2  one-hot write grant (00 when idle)
- GNT_R  output  2  one-hot read grant (00 when idle)

## Operation
- Write FSM states: W_IDLE, W_ADDR, W_RESP. Read FSM states: R_IDLE, R_ADDR, R_RESP. The two FSMs are fully independent and may be active concurrently, including for the same requester.
- Write request for requester n: Sn_AWVALID | Sn_WVALID. Read request: Sn_ARVALID.
- W_IDLE: no forwarding. If any request is pending, register the grant and go to W_ADDR.
  - One requester: grant it.
  - Both: grant the requester that was not granted last (last_w pointer).
- W_ADDR: forward the granted requester g combinationally.
  - M_AWVALID = Sg_AWVALID & ~aw_done; Sg_AWREADY = M_AWREADY & ~aw_done.
  - W channel is forwarded the same way, gated by w_done.
  - aw_done and w_done set on their respective handshakes.
  - When both are set (same cycle allowed), clear the flags and go to W_RESP.
- W_RESP: Sg_BVALID = M_BVALID; M_BREADY = Sg_BREADY. On M_BVALID & M_BREADY: last_w <= g, go to W_IDLE.
- R_ADDR: M_ARVALID = Sg_ARVALID; Sg_ARREADY = M_ARREADY. On the handshake, go to R_RESP.
- R_RESP: Sg_RVALID = M_RVALID; Sg_RDATA = M_RDATA; M_RREADY = Sg_RREADY. On the handshake: last_r <= g, go to R_IDLE.
- Non-granted requester: READY and VALID outputs are 0, RDATA is 0. Its pending VALID is held (AXI rule) until it is granted.
- Idle state: M_ address, data and strobe outputs are 0, M_ VALID/READY are 0, GNT is 00.

## Timing
- Reset (asynchronous, immediate):
  - FSMs go to IDLE; aw_done, w_done and GNT_* clear.
  - last_w = last_r = 1, so requester 0 wins the first tie.
  - Every output is 0.
- Reset mid-transaction drops it silently; the slave shares ARESETn.
- Arbitration latency: request seen in IDLE at edge t, GNT and forwarding valid from edge t+1.
- Back-to-back overhead: one IDLE cycle between transactions on a path.
- Minimum write, slave ready everywhere: IDLE (1) + ADDR (1) + RESP (≥1 cycle after slave BVALID).
- Priority pointer updates only on response completion; a requester that drops its request before grant is not recorded.
- Grant is held through ADDR and RESP regardless of the other requester's activity; no preemption.
- AW before W, W before AW, and AW with W in the same cycle must all complete.
- Stalls of any length on M_ READY, M_BVALID/M_RVALID, Sg_BREADY or Sg_RREADY hold state and all forwarded values stable.

## Test plan
- Single write: S0 writes 0xDEADBEEF to 0x4, WSTRB=0xF. Required: GNT_W=01 one cycle after request, M_ signals carry the S0 values, S0_BVALID follows M_BVALID, S1 sees no READY. A read of 0x4 by S1 then returns 0xDEADBEEF on S1_RDATA.
- Simultaneous writes: S0 writes 0x11111111 to 0x0 and S1 writes 0x22222222 to 0x8, both asserted at the same edge after reset. Required: S0 is granted first, then S1 after one IDLE cycle. Repeat the tie: S0 first again, since last_w=1 after S1 completed.
- Fairness: both requesters issue 8 back-to-back reads each. Required: grants alternate 0,1,0,1… and the RDATA of every completion is routed only to the granted requester.
- Concurrent paths: S0 writes 0x0C while S1 reads 0x0 in the same cycle. Required: GNT_W=01 and GNT_R=10 simultaneously, and both complete.
- Skew and backpressure: S1 asserts WVALID 3 cycles after AWVALID, holds BREADY low for 4 cycles, and the slave holds AWREADY low for 2 cycles. Required: exactly one AW and one W handshake at the slave, and S1_BVALID held until BREADY.
- Reset mid-operation: assert ARESETn low during W_RESP. Required: all outputs are 0 in the same cycle, GNT_W=00, and the next tie after release grants S0.

Source files
------------

// File: rtl/axi_lite_arbiter_2x1.sv
// axi_lite_arbiter_2x1
// Shares one AXI4-Lite slave port between two requesters. The write path
// (AW/W/B) and the read path (AR/R) each have their own round-robin FSM with
// one outstanding transaction. The two paths run independently of each other.
//
// Write FSM
//   state  | meaning
//   W_IDLE | nothing forwarded; arbitrate pending AW/W requests
//   W_ADDR | forward AW and W of the granted requester until both handshake
//   W_RESP | forward B between slave and granted requester
//
// Read FSM
//   state  | meaning
//   R_IDLE | nothing forwarded; arbitrate pending AR requests
//   R_ADDR | forward AR of the granted requester until it handshakes
//   R_RESP | forward R between slave and granted requester

module axi_lite_arbiter_2x1 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,

    // requester 0
    input  logic [ADDR_WIDTH-1:0]   S0_AWADDR,
    input  logic                    S0_AWVALID,
    output logic                    S0_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S0_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
    input  logic                    S0_WVALID,
    output logic                    S0_WREADY,
    output logic                    S0_BVALID,
    input  logic                    S0_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S0_ARADDR,
    input  logic                    S0_ARVALID,
    output logic                    S0_ARREADY,
    output logic [DATA_WIDTH-1:0]   S0_RDATA,
    output logic                    S0_RVALID,
    input  logic                    S0_RREADY,

    // requester 1
    input  logic [ADDR_WIDTH-1:0]   S1_AWADDR,
    input  logic                    S1_AWVALID,
    output logic                    S1_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S1_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
    input  logic                    S1_WVALID,
    output logic                    S1_WREADY,
    output logic                    S1_BVALID,
    input  logic                    S1_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S1_ARADDR,
    input  logic                    S1_ARVALID,
    output logic                    S1_ARREADY,
    output logic [DATA_WIDTH-1:0]   S1_RDATA,
    output logic                    S1_RVALID,
    input  logic                    S1_RREADY,

    // toward the shared slave
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,

    output logic [1:0]              GNT_W,
    output logic [1:0]              GNT_R
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    // Round-robin pick: a lone requester always wins; on a tie the one that
    // did not complete last wins. last is the index of the last completer.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] pick;
        if (req == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
        return pick;
    endfunction

    // ---------------------------------------------------------------------
    // write path state
    // ---------------------------------------------------------------------
    w_state_t w_state, w_state_nxt;
    logic [1:0] gnt_w, gnt_w_nxt;
    logic       last_w, last_w_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;

    // ---------------------------------------------------------------------
    // read path state
    // ---------------------------------------------------------------------
    r_state_t r_state, r_state_nxt;
    logic [1:0] gnt_r, gnt_r_nxt;
    logic       last_r, last_r_nxt;

    // requests seen by the arbiters
    logic [1:0] w_req;
    logic [1:0] r_req;

    assign w_req = {S1_AWVALID | S1_WVALID, S0_AWVALID | S0_WVALID};
    assign r_req = {S1_ARVALID, S0_ARVALID};

    // index of the granted requester (only meaningful while a grant is held)
    logic w_sel;
    logic r_sel;

    assign w_sel = gnt_w[1];
    assign r_sel = gnt_r[1];

    // granted requester's channel signals
    logic [ADDR_WIDTH-1:0] sel_awaddr;
    logic                  sel_awvalid;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_wstrb;
    logic                  sel_wvalid;
    logic                  sel_bready;
    logic [ADDR_WIDTH-1:0] sel_araddr;
    logic                  sel_arvalid;
    logic                  sel_rready;

    assign sel_awaddr  = w_sel ? S1_AWADDR  : S0_AWADDR;
    assign sel_awvalid = w_sel ? S1_AWVALID : S0_AWVALID;
    assign sel_wdata   = w_sel ? S1_WDATA   : S0_WDATA;
    assign sel_wstrb   = w_sel ? S1_WSTRB   : S0_WSTRB;
    assign sel_wvalid  = w_sel ? S1_WVALID  : S0_WVALID;
    assign sel_bready  = w_sel ? S1_BREADY  : S0_BREADY;
    assign sel_araddr  = r_sel ? S1_ARADDR  : S0_ARADDR;
    assign sel_arvalid = r_sel ? S1_ARVALID : S0_ARVALID;
    assign sel_rready  = r_sel ? S1_RREADY  : S0_RREADY;

    // slave-side responses routed back toward the granted requester
    logic                  sel_awready;
    logic                  sel_wready;
    logic                  sel_bvalid;
    logic                  sel_arready;
    logic                  sel_rvalid;
    logic [DATA_WIDTH-1:0] sel_rdata;

    // handshakes at the slave port during W_ADDR
    logic aw_hs;
    logic w_hs;

    // Write path state register; reset biases the first tie toward requester 0.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            gnt_w   <= 2'b00;
            last_w  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            gnt_w   <= gnt_w_nxt;
            last_w  <= last_w_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    // Write path next-state and forwarding; AW and W complete in either order.
    always_comb begin
        w_state_nxt = w_state;
        gnt_w_nxt   = gnt_w;
        last_w_nxt  = last_w;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        M_AWADDR    = '0;
        M_AWVALID   = 1'b0;
        M_WDATA     = '0;
        M_WSTRB     = '0;
        M_WVALID    = 1'b0;
        M_BREADY    = 1'b0;
        sel_awready = 1'b0;
        sel_wready  = 1'b0;
        sel_bvalid  = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;

        unique case (w_state)
            W_IDLE: begin
                if (|w_req) begin
                    gnt_w_nxt   = rr_pick(w_req, last_w);
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                M_AWADDR    = sel_awaddr;
                M_AWVALID   = sel_awvalid & ~aw_done;
                sel_awready = M_AWREADY & ~aw_done;
                M_WDATA     = sel_wdata;
                M_WSTRB     = sel_wstrb;
                M_WVALID    = sel_wvalid & ~w_done;
                sel_wready  = M_WREADY & ~w_done;
                aw_hs       = M_AWVALID & M_AWREADY;
                w_hs        = M_WVALID & M_WREADY;
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = W_RESP;
                end else begin
                    aw_done_nxt = aw_done | aw_hs;
                    w_done_nxt  = w_done | w_hs;
                end
            end
            W_RESP: begin
                sel_bvalid = M_BVALID;
                M_BREADY   = sel_bready;
                if (M_BVALID && sel_bready) begin
                    last_w_nxt  = w_sel;
                    gnt_w_nxt   = 2'b00;
                    w_state_nxt = W_IDLE;
                end
            end
            default: begin
                gnt_w_nxt   = 2'b00;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                w_state_nxt = W_IDLE;
            end
        endcase
    end

    // Read path state register; reset biases the first tie toward requester 0.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            gnt_r   <= 2'b00;
            last_r  <= 1'b1;
        end else begin
            r_state <= r_state_nxt;
            gnt_r   <= gnt_r_nxt;
            last_r  <= last_r_nxt;
        end
    end

    // Read path next-state and forwarding.
    always_comb begin
        r_state_nxt = r_state;
        gnt_r_nxt   = gnt_r;
        last_r_nxt  = last_r;
        M_ARADDR    = '0;
        M_ARVALID   = 1'b0;
        M_RREADY    = 1'b0;
        sel_arready = 1'b0;
        sel_rvalid  = 1'b0;
        sel_rdata   = '0;

        unique case (r_state)
            R_IDLE: begin
                if (|r_req) begin
                    gnt_r_nxt   = rr_pick(r_req, last_r);
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                M_ARADDR    = sel_araddr;
                M_ARVALID   = sel_arvalid;
                sel_arready = M_ARREADY;
                if (sel_arvalid && M_ARREADY) begin
                    r_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                sel_rvalid = M_RVALID;
                sel_rdata  = M_RDATA;
                M_RREADY   = sel_rready;
                if (M_RVALID && sel_rready) begin
                    last_r_nxt  = r_sel;
                    gnt_r_nxt   = 2'b00;
                    r_state_nxt = R_IDLE;
                end
            end
            default: begin
                gnt_r_nxt   = 2'b00;
                r_state_nxt = R_IDLE;
            end
        endcase
    end

    // Return channels reach only the granted requester; the other sees zeros.
    assign S0_AWREADY = gnt_w[0] & sel_awready;
    assign S0_WREADY  = gnt_w[0] & sel_wready;
    assign S0_BVALID  = gnt_w[0] & sel_bvalid;
    assign S1_AWREADY = gnt_w[1] & sel_awready;
    assign S1_WREADY  = gnt_w[1] & sel_wready;
    assign S1_BVALID  = gnt_w[1] & sel_bvalid;

    assign S0_ARREADY = gnt_r[0] & sel_arready;
    assign S0_RVALID  = gnt_r[0] & sel_rvalid;
    assign S0_RDATA   = gnt_r[0] ? sel_rdata : '0;
    assign S1_ARREADY = gnt_r[1] & sel_arready;
    assign S1_RVALID  = gnt_r[1] & sel_rvalid;
    assign S1_RDATA   = gnt_r[1] ? sel_rdata : '0;

    assign GNT_W = gnt_w;
    assign GNT_R = gnt_r;

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// Bench for axi_lite_arbiter_2x1: two requester drivers, a small AXI4-Lite
// slave model behind the arbiter, and scoreboards for slave-side writes,
// write completion order and read completion order/data.

module tb_axi_lite_arbiter_2x1;

    logic        aclk;
    logic        aresetn;

    logic [3:0]  s_awaddr  [2];
    logic        s_awvalid [2];
    logic        s_awready [2];
    logic [31:0] s_wdata   [2];
    logic [3:0]  s_wstrb   [2];
    logic        s_wvalid  [2];
    logic        s_wready  [2];
    logic        s_bvalid  [2];
    logic        s_bready  [2];
    logic [3:0]  s_araddr  [2];
    logic        s_arvalid [2];
    logic        s_arready [2];
    logic [31:0] s_rdata   [2];
    logic        s_rvalid  [2];
    logic        s_rready  [2];

    logic [3:0]  m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic        sl_bvalid;
    logic        m_bready;
    logic [3:0]  m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] sl_rdata;
    logic        sl_rvalid;
    logic        m_rready;
    logic [1:0]  gnt_w;
    logic [1:0]  gnt_r;

    axi_lite_arbiter_2x1 #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(aclk), .ARESETn(aresetn),
        .S0_AWADDR(s_awaddr[0]), .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
        .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
        .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
        .S0_ARADDR(s_araddr[0]), .S0_ARVALID(s_arvalid[0]), .S0_ARREADY(s_arready[0]),
        .S0_RDATA(s_rdata[0]), .S0_RVALID(s_rvalid[0]), .S0_RREADY(s_rready[0]),
        .S1_AWADDR(s_awaddr[1]), .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
        .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
        .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
        .S1_ARADDR(s_araddr[1]), .S1_ARVALID(s_arvalid[1]), .S1_ARREADY(s_arready[1]),
        .S1_RDATA(s_rdata[1]), .S1_RVALID(s_rvalid[1]), .S1_RREADY(s_rready[1]),
        .M_AWADDR(m_awaddr), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
        .M_BVALID(sl_bvalid), .M_BREADY(m_bready),
        .M_ARADDR(m_araddr), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
        .M_RDATA(sl_rdata), .M_RVALID(sl_rvalid), .M_RREADY(m_rready),
        .GNT_W(gnt_w), .GNT_R(gnt_r)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboards
    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;
    typedef struct packed {
        logic        req;
        logic [31:0] data;
    } rd_t;

    wr_t         slv_q [$];
    int          wr_order_q [$];
    rd_t         rd_q [$];
    logic [31:0] ref_mem [4];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic exp_slave_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wr_t e;
        e.addr = addr; e.data = data; e.strb = strb;
        slv_q.push_back(e);
        ref_mem[addr[3:2]] = merge(ref_mem[addr[3:2]], data, strb);
    endtask

    task automatic exp_write(input int n, input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_slave_write(addr, data, strb);
        wr_order_q.push_back(n);
    endtask

    task automatic exp_read(input int n, input logic [3:0] addr);
        rd_t e;
        e.req = n[0]; e.data = ref_mem[addr[3:2]];
        rd_q.push_back(e);
    endtask

    // ---------------- slave model ----------------
    logic [31:0] smem [4];
    logic        have_aw, have_w;
    logic [3:0]  p_addr, p_strb;
    logic [31:0] p_data;
    int          aw_wait = 0;
    int          aw_stall_cfg = 0;
    int          sl_aw_cnt = 0;
    int          sl_w_cnt = 0;
    logic        ga, gw;
    logic [3:0]  ca, cs;
    logic [31:0] cd;
    wr_t         sl_e;

    assign m_awready = (aw_wait >= aw_stall_cfg);
    assign m_wready  = 1'b1;
    assign m_arready = 1'b1;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            have_aw   <= 1'b0;
            have_w    <= 1'b0;
            sl_bvalid <= 1'b0;
            sl_rvalid <= 1'b0;
            sl_rdata  <= 32'h0;
            aw_wait   <= 0;
        end else begin
            ga = have_aw | (m_awvalid & m_awready);
            gw = have_w | (m_wvalid & m_wready);
            ca = have_aw ? p_addr : m_awaddr;
            cd = have_w ? p_data : m_wdata;
            cs = have_w ? p_strb : m_wstrb;
            if (m_awvalid & m_awready) sl_aw_cnt <= sl_aw_cnt + 1;
            if (m_wvalid & m_wready) sl_w_cnt <= sl_w_cnt + 1;
            if (m_awvalid & ~m_awready) aw_wait <= aw_wait + 1;
            else aw_wait <= 0;
            if (sl_bvalid & m_bready) sl_bvalid <= 1'b0;
            if (ga && gw) begin
                smem[ca[3:2]] <= merge(smem[ca[3:2]], cd, cs);
                sl_bvalid <= 1'b1;
                have_aw   <= 1'b0;
                have_w    <= 1'b0;
                chk("slv_q_nonempty", slv_q.size() > 0, 1);
                if (slv_q.size() > 0) begin
                    sl_e = slv_q.pop_front();
                    chk("slv_write", {ca, cd, cs}, sl_e);
                end
            end else begin
                if (m_awvalid & m_awready) begin have_aw <= 1'b1; p_addr <= m_awaddr; end
                if (m_wvalid & m_wready) begin have_w <= 1'b1; p_data <= m_wdata; p_strb <= m_wstrb; end
            end
            if (sl_rvalid & m_rready) sl_rvalid <= 1'b0;
            if (m_arvalid & m_arready) begin
                sl_rvalid <= 1'b1;
                sl_rdata  <= smem[m_araddr[3:2]];
            end
        end
    end

    // ---------------- per-cycle invariants ----------------
    logic any_out;
    assign any_out = |{s_awready[0], s_awready[1], s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1],
                       s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1], s_rdata[0], s_rdata[1],
                       m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
                       m_araddr, m_arvalid, m_rready, gnt_w, gnt_r};

    logic mon_leak, mon_idle;
    always @(negedge aclk) begin
        #2;
        mon_leak = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if (!gnt_w[n]) mon_leak = mon_leak | s_awready[n] | s_wready[n] | s_bvalid[n];
            if (!gnt_r[n]) mon_leak = mon_leak | s_arready[n] | s_rvalid[n] | (|s_rdata[n]);
        end
        mon_idle = 1'b0;
        if (gnt_w == 2'b00) mon_idle = |{m_awvalid, m_wvalid, m_bready, m_awaddr, m_wdata, m_wstrb};
        if (gnt_r == 2'b00) mon_idle = mon_idle | (|{m_arvalid, m_rready, m_araddr});
        chk("ungranted_quiet", mon_leak, 0);
        chk("idle_quiet", mon_idle, 0);
        chk("gnt_onehot", {$countones(gnt_w) <= 1, $countones(gnt_r) <= 1}, 2'b11);
    end

    // ---------------- requester drivers (enter and leave at a negedge) ----------------
    task automatic do_write(input int n, input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, output int gnt_cyc);
        int cyc, seen;
        bit aw_ok, w_ok, aw_hs, w_hs, b_done;
        cyc = 0; seen = 0; aw_ok = 0; w_ok = 0; b_done = 0; gnt_cyc = -1;
        s_awaddr[n] = addr; s_wdata[n] = data; s_wstrb[n] = strb; s_bready[n] = 1'b0;
        while (!(aw_ok && w_ok) && cyc < 200) begin
            if (!aw_ok && cyc >= aw_dly) s_awvalid[n] = 1'b1;
            if (!w_ok && cyc >= w_dly) s_wvalid[n] = 1'b1;
            #1;
            if (gnt_cyc < 0 && gnt_w[n]) gnt_cyc = cyc;
            aw_hs = s_awvalid[n] & s_awready[n];
            w_hs  = s_wvalid[n] & s_wready[n];
            @(negedge aclk);
            cyc++;
            if (aw_hs) begin aw_ok = 1; s_awvalid[n] = 1'b0; end
            if (w_hs) begin w_ok = 1; s_wvalid[n] = 1'b0; end
        end
        while (aw_ok && w_ok && !b_done && cyc < 400) begin
            s_bready[n] = (seen >= b_dly);
            #1;
            chk("b_fwd", s_bvalid[n], sl_bvalid);
            if (seen > 0) chk("b_hold", s_bvalid[n], 1);
            if (s_bvalid[n]) begin
                seen++;
                if (s_bready[n]) begin
                    b_done = 1;
                    chk("gnt_w_at_b", gnt_w, (n == 0) ? 2'b01 : 2'b10);
                    chk("wr_order_nonempty", wr_order_q.size() > 0, 1);
                    if (wr_order_q.size() > 0) chk("wr_order", n, wr_order_q.pop_front());
                end
            end
            @(negedge aclk);
            cyc++;
        end
        s_awvalid[n] = 1'b0; s_wvalid[n] = 1'b0; s_bready[n] = 1'b0;
        chk("wr_done", b_done, 1);
    endtask

    task automatic do_read(input int n, input logic [3:0] addr, input int r_dly);
        int cyc, seen;
        bit ar_ok, hs, r_done;
        rd_t e;
        cyc = 0; seen = 0; ar_ok = 0; r_done = 0;
        s_araddr[n] = addr; s_rready[n] = 1'b0;
        while (!ar_ok && cyc < 200) begin
            s_arvalid[n] = 1'b1;
            #1;
            hs = s_arready[n];
            @(negedge aclk);
            cyc++;
            if (hs) begin ar_ok = 1; s_arvalid[n] = 1'b0; end
        end
        while (ar_ok && !r_done && cyc < 400) begin
            s_rready[n] = (seen >= r_dly);
            #1;
            chk("r_fwd", s_rvalid[n], sl_rvalid);
            if (s_rvalid[n]) begin
                seen++;
                if (s_rready[n]) begin
                    r_done = 1;
                    chk("gnt_r_at_r", gnt_r, (n == 0) ? 2'b01 : 2'b10);
                    chk("rd_q_nonempty", rd_q.size() > 0, 1);
                    if (rd_q.size() > 0) begin
                        e = rd_q.pop_front();
                        chk("rd_req", n, e.req);
                        chk("rd_data", s_rdata[n], e.data);
                    end
                end
            end
            @(negedge aclk);
            cyc++;
        end
        s_arvalid[n] = 1'b0; s_rready[n] = 1'b0;
        chk("rd_done", r_done, 1);
    endtask

    task automatic tie_writes(input logic [31:0] d0, input logic [31:0] d1);
        int g0, g1;
        exp_write(0, 4'h0, d0, 4'hF);
        exp_write(1, 4'h8, d1, 4'hF);
        @(negedge aclk);
        fork
            do_write(0, 4'h0, d0, 4'hF, 0, 0, 0, g0);
            do_write(1, 4'h8, d1, 4'hF, 0, 0, 0, g1);
        join
        chk("tie_gnt0_lat", g0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gc, a0, w0;
        bit got_b, ahs, whs;
        aresetn = 1'b0;
        for (int n = 0; n < 2; n++) begin
            s_awaddr[n] = '0; s_awvalid[n] = 0; s_wdata[n] = '0; s_wstrb[n] = '0; s_wvalid[n] = 0;
            s_bready[n] = 0; s_araddr[n] = '0; s_arvalid[n] = 0; s_rready[n] = 0;
        end
        for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_outs", any_out, 0);
        chk("rst_gnt", {gnt_w, gnt_r}, 4'b0000);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // simultaneous writes, twice: S0 wins both ties
        tie_writes(32'h11111111, 32'h22222222);
        tie_writes(32'h33333333, 32'h44444444);

        // single write by S0, read back by S1
        exp_write(0, 4'h4, 32'hDEADBEEF, 4'hF);
        @(negedge aclk);
        do_write(0, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, gc);
        chk("single_gnt_lat", gc, 1);
        exp_read(1, 4'h4);
        @(negedge aclk);
        do_read(1, 4'h4, 0);

        // concurrent write (S0) and read (S1)
        exp_write(0, 4'hC, 32'h0C0C0C0C, 4'hF);
        exp_read(1, 4'h0);
        @(negedge aclk);
        fork
            do_write(0, 4'hC, 32'h0C0C0C0C, 4'hF, 0, 0, 0, gc);
            do_read(1, 4'h0, 0);
            begin
                @(negedge aclk);
                #3;
                chk("concurrent_gnt", {gnt_w, gnt_r}, 4'b0110);
            end
        join

        // fairness: 8 back-to-back reads per requester, alternating grants
        for (int i = 0; i < 8; i++) begin
            exp_read(0, 4'((i % 4) * 4));
            exp_read(1, 4'(((i + 2) % 4) * 4));
        end
        @(negedge aclk);
        fork
            begin
                for (int i = 0; i < 8; i++) do_read(0, 4'((i % 4) * 4), 0);
            end
            begin
                for (int j = 0; j < 8; j++) do_read(1, 4'(((j + 2) % 4) * 4), 1);
            end
        join

        // W before AW on S0
        exp_write(0, 4'h8, 32'h5A5A0000, 4'hF);
        @(negedge aclk);
        do_write(0, 4'h8, 32'h5A5A0000, 4'hF, 2, 0, 0, gc);

        // skew and backpressure on S1, partial strobe
        a0 = sl_aw_cnt; w0 = sl_w_cnt;
        aw_stall_cfg = 2;
        exp_write(1, 4'h4, 32'hA5A5A5A5, 4'b0101);
        @(negedge aclk);
        do_write(1, 4'h4, 32'hA5A5A5A5, 4'b0101, 0, 3, 4, gc);
        aw_stall_cfg = 0;
        chk("skew_aw_count", sl_aw_cnt - a0, 1);
        chk("skew_w_count", sl_w_cnt - w0, 1);
        exp_read(0, 4'h4);
        @(negedge aclk);
        do_read(0, 4'h4, 2);

        // reset while in W_RESP
        exp_slave_write(4'h0, 32'h55AA55AA, 4'hF);
        @(negedge aclk);
        s_awaddr[0] = 4'h0; s_wdata[0] = 32'h55AA55AA; s_wstrb[0] = 4'hF;
        s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b0;
        got_b = 0;
        for (int c = 0; c < 50 && !got_b; c++) begin
            #1;
            got_b = s_bvalid[0];
            ahs = s_awvalid[0] & s_awready[0];
            whs = s_wvalid[0] & s_wready[0];
            if (!got_b) begin
                @(negedge aclk);
                if (ahs) s_awvalid[0] = 1'b0;
                if (whs) s_wvalid[0] = 1'b0;
            end
        end
        chk("rst_reached_resp", got_b, 1);
        chk("rst_pre_gnt", gnt_w, 2'b01);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_outs", any_out, 0);
        chk("rst_mid_gnt", gnt_w, 2'b00);
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        tie_writes(32'h66666666, 32'h77777777);

        repeat (3) @(negedge aclk);
        chk("end_slv_q", slv_q.size(), 0);
        chk("end_wr_order_q", wr_order_q.size(), 0);
        chk("end_rd_q", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
